// File: rtl/uart_rx.sv
// uart_rx: memory-mapped 8N1 UART receiver with a small byte FIFO.
// The serial line is synchronised, deserialised LSB first and queued.
// The CPU reads DATA (which pops the head) or STATUS (which clears the sticky flags)
// through the same address window as the transmit side.
module uart_rx #(
  parameter int LOGD         = 7,
  parameter int CLKS_PER_BIT = 868,
  parameter int LOGF         = 2
) (
  input  logic        clk,
  input  logic        i_reset,
  input  logic        uart_txd_in,
  input  logic        rd_valid,
  input  logic [31:0] rd_addr,
  output logic [31:0] rd_data,
  output logic        rx_nonempty
);

  localparam int            DEPTH     = 1 << LOGF;
  localparam int            CW        = $clog2(CLKS_PER_BIT + 1);
  localparam logic [CW-1:0] BIT_CNT   = CW'(CLKS_PER_BIT);
  localparam logic [CW-1:0] HALF_CNT  = CW'(CLKS_PER_BIT / 2);
  localparam logic [LOGF:0] DEPTH_CNT = (LOGF + 1)'(DEPTH);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_WAIT_HIGH
  } state_t;

  // Receiver state
  logic [1:0]      sync_q;
  logic            rxs;
  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [2:0]      idx_q, idx_d;
  logic [7:0]      sh_q, sh_d;
  logic            cnt_done;
  logic            push;
  logic            ferr_set;

  // FIFO and flags
  logic [7:0]      mem [DEPTH];
  logic [LOGF-1:0] wr_ptr_q, rd_ptr_q;
  logic [LOGF:0]   count_q, count_d;
  logic            ferr_q, ovr_q;
  logic            nonempty, full, pop, do_write, ovr_set;

  // Bus decode
  logic            hit, data_rd, stat_rd;
  logic [31:0]     status_word;
  logic            unused_addr;

  assign rxs      = sync_q[1];
  assign cnt_done = (cnt_q == CW'(1));

  // Synchroniser and receiver registers.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (i_reset) begin
      sync_q  <= 2'b11;
      state_q <= S_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      sh_q    <= '0;
    end else begin
      sync_q  <= {sync_q[0], uart_txd_in};
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      sh_q    <= sh_d;
    end
  end

  // Frame FSM: bit timing, sampling, push and framing-error detection.
  // NOTE: every output is given a default first so no path leaves a latch.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    idx_d    = idx_q;
    sh_d     = sh_q;
    push     = 1'b0;
    ferr_set = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (!rxs) begin
          state_d = S_START;
          cnt_d   = HALF_CNT;
        end
      end
      S_START: begin
        if (!cnt_done) begin
          cnt_d = cnt_q - CW'(1);
        end else if (!rxs) begin
          state_d = S_DATA;
          idx_d   = '0;
          cnt_d   = BIT_CNT;
        end else begin
          state_d = S_IDLE;  // glitch: start bit did not last to mid-bit
        end
      end
      S_DATA: begin
        if (!cnt_done) begin
          cnt_d = cnt_q - CW'(1);
        end else begin
          sh_d  = {rxs, sh_q[7:1]};
          idx_d = idx_q + 3'd1;
          cnt_d = BIT_CNT;
          if (idx_q == 3'd7) state_d = S_STOP;
        end
      end
      S_STOP: begin
        if (!cnt_done) begin
          cnt_d = cnt_q - CW'(1);
        end else if (rxs) begin
          push    = 1'b1;
          state_d = S_IDLE;
        end else begin
          ferr_set = 1'b1;
          state_d  = S_WAIT_HIGH;  // wait out a break so it flags only once
        end
      end
      S_WAIT_HIGH: begin
        if (rxs) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Remaining address bits are don't-cares for this block.
  assign unused_addr = ^rd_addr;

  assign hit      = rd_valid && rd_addr[LOGD];
  assign data_rd  = hit && !rd_addr[2];
  assign stat_rd  = hit && rd_addr[2];

  assign nonempty = (count_q != '0);
  assign full     = (count_q == DEPTH_CNT);
  assign pop      = data_rd && nonempty;
  assign do_write = push && (!full || pop);
  assign ovr_set  = push && full && !pop;

  assign status_word = {{(28 - LOGF - 1){1'b0}}, count_q, ferr_q, ovr_q, full, nonempty};

  // Next FIFO occupancy from the write/pop pair.
  always_comb begin
    count_d = count_q;
    if (do_write && !pop)      count_d = count_q + (LOGF + 1)'(1);
    else if (!do_write && pop) count_d = count_q - (LOGF + 1)'(1);
  end

  // FIFO storage.
  // NOTE: the data array has no reset; pointers and count alone define which entries are valid.
  always_ff @(posedge clk) begin
    if (do_write) mem[wr_ptr_q] <= sh_q;
  end

  // FIFO pointers, occupancy, sticky flags and the interrupt/poll output.
  always_ff @(posedge clk) begin
    if (i_reset) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      ferr_q      <= 1'b0;
      ovr_q       <= 1'b0;
      rx_nonempty <= 1'b0;
    end else begin
      if (do_write) wr_ptr_q <= wr_ptr_q + LOGF'(1);
      if (pop)      rd_ptr_q <= rd_ptr_q + LOGF'(1);
      count_q     <= count_d;
      // A set in the same cycle as a STATUS-read clear wins.
      ferr_q      <= ferr_set | (ferr_q & ~stat_rd);
      ovr_q       <= ovr_set  | (ovr_q  & ~stat_rd);
      rx_nonempty <= (count_d != '0);
    end
  end

  // Registered read data; holds until the next load strobe.
  always_ff @(posedge clk) begin
    if (i_reset) begin
      rd_data <= '0;
    end else if (rd_valid) begin
      if (!hit)          rd_data <= '0;
      else if (stat_rd)  rd_data <= status_word;
      else if (nonempty) rd_data <= {23'b0, 1'b1, mem[rd_ptr_q]};
      else               rd_data <= '0;
    end
  end

endmodule

// File: doc/uart_rx.md
# uart_rx

Memory-mapped UART receiver: the receive counterpart of the write-only UART transmit path. It deserialises 8N1 frames from the board's serial line, queues received bytes in a small FIFO, and exposes data and status words to the CPU load path. It decodes the same address bit as the transmit side, so a single UART window serves both directions.

## Interface
- `LOGD`, default 7: address bit that selects the UART window; a read hits when `rd_addr[LOGD]` = 1.
- `CLKS_PER_BIT`, default 868: clock cycles per bit (100 MHz / 115200); legal minimum is 4.
- `LOGF`, default 2: log2 of the FIFO depth (4 entries).
- `clk`  in  1: single clock.
- `i_reset`  in  1: synchronous, active-high reset.
- `uart_txd_in`  in  1: asynchronous serial line; idles high.
- `rd_valid`  in  1: load strobe, one cycle wide.
- `rd_addr`  in  32: load address; bit `LOGD` selects the UART, bit 2 selects the register (0 = DATA, 1 = STATUS).
- `rd_data`  out  32: registered read data.
- `rx_nonempty`  out  1: FIFO holds at least one byte; intended as an interrupt or poll source.

## Operation
- **Input synchroniser.** Two flops on `uart_txd_in`, both reset to 1. All logic uses the second flop, `rxs`.
- **FSM states and transitions:**
  - IDLE: `rxs` = 0 → START, with the counter loaded to `CLKS_PER_BIT/2` (integer division).
  - START: when the counter expires, sample `rxs`.
    - Sample = 0 → DATA, with bit index 0 and the counter loaded to `CLKS_PER_BIT`.
    - Sample = 1 → IDLE. This is a glitch; no flag is set.
  - DATA: on each expiry, shift `rxs` into the shift register LSB first.
    - After bit 7 → STOP.
    - Otherwise reload the counter to `CLKS_PER_BIT`.
  - STOP: on expiry, sample `rxs`.
    - Sample = 1 → push the byte and go to IDLE.
    - Sample = 0 → set sticky FERR, discard the byte, and go to WAIT_HIGH.
  - WAIT_HIGH: stay until `rxs` = 1, then go to IDLE. A break condition therefore produces exactly one FERR.
- **FIFO.** Depth is 2^`LOGF`. Read and write pointers are `LOGF` bits wide and wrap naturally. The count is `LOGF`+1 bits wide.
  - Push while full with no pop in the same cycle: drop the byte and set sticky OVR.
  - Push and pop in the same cycle, including when full: both take effect and the count is unchanged; OVR is not set.
- **DATA read** (`rd_valid`, `rd_addr[LOGD]` = 1, `rd_addr[2]` = 0):
  - Nonempty: `rd_data` = {23'b0, 1'b1, head byte}, and the head is popped.
  - Empty: `rd_data` = 0 and there is no pop.
- **STATUS read** (`rd_addr[2]` = 1): `rd_data` = {count padded to bits [31:4], FERR[3], OVR[2], full[1], nonempty[0]}.
  - The value returned reflects the flags before the clear.
  - The read clears FERR and OVR.
  - If a flag is being set in the same cycle as the clear, the set wins.
- **Non-UART reads** (`rd_valid` with `rd_addr[LOGD]` = 0): `rd_data` = 0 and no side effects.
- **`rx_nonempty`** = (count != 0). It is registered from FIFO state.

## Timing
- **Reset values:**
  - `rd_data` = 0, `rx_nonempty` = 0, FERR = OVR = 0.
  - FIFO empty, FSM in IDLE, synchroniser flops = 1.
  - Reset mid-frame aborts the frame; no push occurs.
- **Frame timing.** Let T0 be the first cycle with `rxs` = 0 in IDLE, and H = `CLKS_PER_BIT/2`, N = `CLKS_PER_BIT`.
  - Start-bit sample at T0+H.
  - Data bit k sampled at T0+H+(k+1)·N.
  - Stop-bit sample and push at T0+H+9·N.
  - `rx_nonempty` and STATUS reflect the push from the next cycle.
- **Line-to-detection delay.** `uart_txd_in` to `rxs` is 2 cycles.
- **Read latency.** `rd_data` is valid 1 cycle after `rd_valid` and holds until the next `rd_valid`.
- **Back-to-back operation:**
  - The FSM re-arms in IDLE on the cycle after the stop sample, so a start bit immediately following the stop bit is received.
  - Consecutive reads on consecutive cycles each pop one entry.

## Test plan
All scenarios use `CLKS_PER_BIT` = 16 and `LOGF` = 2.
- **Single frame.** Send 0xA5 as 8N1. Then:
  - `rx_nonempty` rises at T0+8+144+1.
  - STATUS = 0x00000011.
  - DATA read returns 0x1A5, after which `rx_nonempty` = 0.
- **Glitch rejection.** Hold a low pulse of 4 cycles on an idle line → no push, FERR = 0, FSM back in IDLE.
- **Overrun and FIFO wrap.** Send 5 bytes 0x01..0x05 without reading. Then:
  - STATUS = 0x00000047 (count 4, OVR, full, nonempty), and the STATUS read clears OVR.
  - Four DATA reads return 0x101..0x104.
  - A fifth DATA read returns 0.
- **Framing error and break.** Send 0x3C with the stop bit low, then hold the line low for 40 bits and release. Then:
  - FERR = 1 and nothing is queued.
  - After release, a frame carrying 0x77 is received correctly.
- **Simultaneous events:**
  - With the FIFO full, issue a DATA read in the same cycle as a push → no overrun; count stays 4.
  - A STATUS read in the cycle OVR sets → OVR stays 1.
- **Reset mid-frame.** Assert `i_reset` during data bit 3 → all outputs 0, FIFO empty; the next full frame is received intact.
